// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush sequencer: state encodings,
// stall-vector encodings and the request-to-stall-vector priority encoder.
package pipeline_ctrl_pkg;

   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } state_e;

   localparam int STALL_W = 6;

   localparam logic [STALL_W-1:0] STALL_NONE = 6'b000000;
   localparam logic [STALL_W-1:0] STALL_IF   = 6'b000011;
   localparam logic [STALL_W-1:0] STALL_ID   = 6'b000111;
   localparam logic [STALL_W-1:0] STALL_EX   = 6'b001111;
   localparam logic [STALL_W-1:0] STALL_MEM  = 6'b011111;

   // The latest requesting stage wins: it freezes itself and everything upstream.
   function automatic logic [STALL_W-1:0] stall_encode(input logic req_if,
                                                       input logic req_id,
                                                       input logic req_ex,
                                                       input logic req_mem);
      logic [STALL_W-1:0] v;
      if (req_mem)     v = STALL_MEM;
      else if (req_ex) v = STALL_EX;
      else if (req_id) v = STALL_ID;
      else if (req_if) v = STALL_IF;
      else             v = STALL_NONE;
      return v;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear; holds at all-ones instead of wrapping.
module sat_counter
   import pipeline_ctrl_pkg::*;
#(
   parameter int W = 8
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         clr_i,
   input  logic         inc_i,
   output logic [W-1:0] cnt_o
);

   logic [W-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clr_i) begin
         cnt_d = '0;
      end else if (inc_i && (cnt_q != {W{1'b1}})) begin
         cnt_d = cnt_q + W'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt_o = cnt_q;

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush sequencer for the 5-stage pipeline: stall vector, exception/ERET
// redirect with a multi-cycle flush, performance counters and a stall watchdog.
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int unsigned FLUSH_CYCLES  = 1,
   parameter logic [31:0] EXCP_VECTOR   = 32'h0000_0020,
   parameter int unsigned STALL_TIMEOUT = 1024
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               stallreq_if,
   input  logic               stallreq_id,
   input  logic               stallreq_ex,
   input  logic               stallreq_mem,
   input  logic               excp_req,
   input  logic               excp_eret,
   input  logic [31:0]        epc,
   output logic [STALL_W-1:0] stall,
   output logic               flush,
   output logic [31:0]        new_pc,
   output logic [31:0]        stall_cnt,
   output logic [15:0]        flush_cnt,
   output logic               stall_timeout
);

   localparam logic [2:0]  FLUSH_LAST = 3'(FLUSH_CYCLES - 1);
   localparam logic [15:0] WD_LIMIT   = 16'(STALL_TIMEOUT);

   state_e             state_q, state_d;
   logic [2:0]         fcnt_q, fcnt_d;
   logic [31:0]        new_pc_q, new_pc_d;
   logic [15:0]        wd_q, wd_d;
   logic               timeout_q, timeout_d;
   logic               any_req;
   logic               accept;
   logic [STALL_W-1:0] stall_vec;
   logic               flush_vec;
   logic               stalling;

   assign any_req = stallreq_if | stallreq_id | stallreq_ex | stallreq_mem;
   // Requests arriving while a flush is in progress are dropped, not queued.
   assign accept  = excp_req && (state_q != ST_FLUSH);

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q <= ST_RUN;
         fcnt_q  <= '0;
      end else begin
         state_q <= state_d;
         fcnt_q  <= fcnt_d;
      end
   end

   always_comb begin
      state_d = state_q;
      fcnt_d  = fcnt_q;
      case (state_q)
         ST_RUN, ST_STALL: begin
            if (accept) begin
               state_d = ST_FLUSH;
               fcnt_d  = FLUSH_LAST;
            end else begin
               state_d = any_req ? ST_STALL : ST_RUN;
            end
         end
         ST_FLUSH: begin
            if (fcnt_q == 3'd0) begin
               state_d = any_req ? ST_STALL : ST_RUN;
            end else begin
               fcnt_d = fcnt_q - 3'd1;
            end
         end
         default: begin
            state_d = ST_RUN;
            fcnt_d  = '0;
         end
      endcase
   end

   // An accepted exception suppresses stalls in its own cycle so the redirect is not held.
   always_comb begin
      stall_vec = STALL_NONE;
      flush_vec = 1'b0;
      case (state_q)
         ST_FLUSH: flush_vec = 1'b1;
         default: begin
            if (!excp_req) begin
               stall_vec = stall_encode(stallreq_if, stallreq_id, stallreq_ex, stallreq_mem);
            end
         end
      endcase
   end

   assign stalling = |stall_vec;

   always_comb begin
      new_pc_d = new_pc_q;
      if (accept) begin
         new_pc_d = excp_eret ? epc : EXCP_VECTOR;
      end
   end

   always_comb begin
      wd_d = '0;
      if (stalling) begin
         wd_d = (wd_q == 16'hFFFF) ? wd_q : wd_q + 16'd1;
      end
      timeout_d = timeout_q | (wd_d == WD_LIMIT);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         new_pc_q  <= '0;
         wd_q      <= '0;
         timeout_q <= 1'b0;
      end else begin
         new_pc_q  <= new_pc_d;
         wd_q      <= wd_d;
         timeout_q <= timeout_d;
      end
   end

   sat_counter #(.W(32)) u_stall_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (1'b0),
      .inc_i  (stalling),
      .cnt_o  (stall_cnt)
   );

   sat_counter #(.W(16)) u_flush_cnt (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (1'b0),
      .inc_i  (accept),
      .cnt_o  (flush_cnt)
   );

   assign stall         = stall_vec;
   assign flush         = flush_vec;
   assign new_pc        = new_pc_q;
   assign stall_timeout = timeout_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Bench for pipeline_ctrl: default-parameter instance driven from a vector table,
// a FLUSH_CYCLES=3/STALL_TIMEOUT=8 instance and a narrow sat_counter for the corner cases.
module tb_pipeline_ctrl;

   typedef struct {
      logic [3:0]  req;   // {mem, ex, id, if}
      logic        ex;
      logic        eret;
      logic [31:0] epc;
      logic [5:0]  e_stall;
      logic        e_flush;
      logic [31:0] e_pc;
      logic [31:0] e_scnt;
      logic [15:0] e_fcnt;
   } vec_t;

   logic clk = 1'b0;
   logic rst = 1'b0;

   logic [3:0]  a_req  = '0;
   logic        a_ex   = 1'b0;
   logic        a_eret = 1'b0;
   logic [31:0] a_epc  = '0;
   logic [5:0]  a_stall;
   logic        a_flush;
   logic [31:0] a_pc;
   logic [31:0] a_scnt;
   logic [15:0] a_fcnt;
   logic        a_to;

   logic [3:0]  b_req  = '0;
   logic        b_ex   = 1'b0;
   logic        b_eret = 1'b0;
   logic [31:0] b_epc  = '0;
   logic [5:0]  b_stall;
   logic        b_flush;
   logic [31:0] b_pc;
   logic [31:0] b_scnt;
   logic [15:0] b_fcnt;
   logic        b_to;

   logic        sat_clr = 1'b0;
   logic        sat_inc = 1'b0;
   logic [3:0]  sat_cnt;

   int n_cmp = 0;
   int n_err = 0;
   vec_t vecs[19];
   vec_t sb[$];

   always #5 clk = ~clk;

   pipeline_ctrl u_dut_a (
      .clk           (clk),
      .rst           (rst),
      .stallreq_if   (a_req[0]),
      .stallreq_id   (a_req[1]),
      .stallreq_ex   (a_req[2]),
      .stallreq_mem  (a_req[3]),
      .excp_req      (a_ex),
      .excp_eret     (a_eret),
      .epc           (a_epc),
      .stall         (a_stall),
      .flush         (a_flush),
      .new_pc        (a_pc),
      .stall_cnt     (a_scnt),
      .flush_cnt     (a_fcnt),
      .stall_timeout (a_to)
   );

   pipeline_ctrl #(.FLUSH_CYCLES(3), .STALL_TIMEOUT(8)) u_dut_b (
      .clk           (clk),
      .rst           (rst),
      .stallreq_if   (b_req[0]),
      .stallreq_id   (b_req[1]),
      .stallreq_ex   (b_req[2]),
      .stallreq_mem  (b_req[3]),
      .excp_req      (b_ex),
      .excp_eret     (b_eret),
      .epc           (b_epc),
      .stall         (b_stall),
      .flush         (b_flush),
      .new_pc        (b_pc),
      .stall_cnt     (b_scnt),
      .flush_cnt     (b_fcnt),
      .stall_timeout (b_to)
   );

   sat_counter #(.W(4)) u_sat (
      .clk_i  (clk),
      .rst_ni (rst),
      .clr_i  (sat_clr),
      .inc_i  (sat_inc),
      .cnt_o  (sat_cnt)
   );

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", nm, act, exp);
      end
   endtask

   function automatic vec_t mk(input logic [3:0] req, input logic ex, input logic eret,
                               input logic [31:0] epc, input logic [5:0] st, input logic fl,
                               input logic [31:0] pc, input logic [31:0] sc, input logic [15:0] fc);
      vec_t v;
      v.req = req; v.ex = ex; v.eret = eret; v.epc = epc;
      v.e_stall = st; v.e_flush = fl; v.e_pc = pc; v.e_scnt = sc; v.e_fcnt = fc;
      return v;
   endfunction

   task automatic apply_a(input vec_t v);
      @(posedge clk);
      #1;
      a_req = v.req; a_ex = v.ex; a_eret = v.eret; a_epc = v.epc;
      sb.push_back(v);
   endtask

   task automatic check_a(input int idx);
      vec_t e;
      @(negedge clk);
      if (sb.size() == 0) begin
         chk($sformatf("vec%0d scoreboard empty", idx), 32'd0, 32'd1);
      end else begin
         e = sb.pop_front();
         chk($sformatf("vec%0d stall", idx), 32'(a_stall), 32'(e.e_stall));
         chk($sformatf("vec%0d flush", idx), 32'(a_flush), 32'(e.e_flush));
         chk($sformatf("vec%0d new_pc", idx), a_pc, e.e_pc);
         chk($sformatf("vec%0d stall_cnt", idx), a_scnt, e.e_scnt);
         chk($sformatf("vec%0d flush_cnt", idx), 32'(a_fcnt), 32'(e.e_fcnt));
      end
   endtask

   task automatic step_b(input logic [3:0] req, input logic ex, input logic eret, input logic [31:0] epc);
      @(posedge clk);
      #1;
      b_req = req; b_ex = ex; b_eret = eret; b_epc = epc;
      @(negedge clk);
   endtask

   initial begin
      // stall/flush sequence for the FLUSH_CYCLES=1 instance, counters from reset
      vecs[0]  = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 0, 32'h0,         32'd0, 16'd0);
      vecs[1]  = mk(4'b0001, 0, 0, 32'h0,         6'b000011, 0, 32'h0,         32'd0, 16'd0);
      vecs[2]  = mk(4'b0010, 0, 0, 32'h0,         6'b000111, 0, 32'h0,         32'd1, 16'd0);
      vecs[3]  = mk(4'b0110, 0, 0, 32'h0,         6'b001111, 0, 32'h0,         32'd2, 16'd0);
      vecs[4]  = mk(4'b0110, 0, 0, 32'h0,         6'b001111, 0, 32'h0,         32'd3, 16'd0);
      vecs[5]  = mk(4'b0110, 0, 0, 32'h0,         6'b001111, 0, 32'h0,         32'd4, 16'd0);
      vecs[6]  = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 0, 32'h0,         32'd5, 16'd0);
      vecs[7]  = mk(4'b1111, 0, 0, 32'h0,         6'b011111, 0, 32'h0,         32'd5, 16'd0);
      vecs[8]  = mk(4'b1000, 1, 0, 32'h0,         6'b000000, 0, 32'h0,         32'd6, 16'd0);
      vecs[9]  = mk(4'b1000, 0, 0, 32'h0,         6'b000000, 1, 32'h20,        32'd6, 16'd1);
      vecs[10] = mk(4'b1000, 0, 0, 32'h0,         6'b011111, 0, 32'h20,        32'd6, 16'd1);
      vecs[11] = mk(4'b0000, 1, 1, 32'h8000_1234, 6'b000000, 0, 32'h20,        32'd7, 16'd1);
      vecs[12] = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 1, 32'h8000_1234, 32'd7, 16'd2);
      vecs[13] = mk(4'b0100, 0, 0, 32'h0,         6'b001111, 0, 32'h8000_1234, 32'd7, 16'd2);
      vecs[14] = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 0, 32'h8000_1234, 32'd8, 16'd2);
      vecs[15] = mk(4'b0000, 1, 0, 32'h0,         6'b000000, 0, 32'h8000_1234, 32'd8, 16'd2);
      vecs[16] = mk(4'b1000, 1, 1, 32'h1111_0000, 6'b000000, 1, 32'h20,        32'd8, 16'd3);
      vecs[17] = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 0, 32'h20,        32'd8, 16'd3);
      vecs[18] = mk(4'b0000, 0, 0, 32'h0,         6'b000000, 0, 32'h20,        32'd8, 16'd3);

      repeat (2) @(posedge clk);
      #1;
      chk("reset a stall", 32'(a_stall), 32'd0);
      chk("reset a flush", 32'(a_flush), 32'd0);
      chk("reset a new_pc", a_pc, 32'd0);
      chk("reset a stall_cnt", a_scnt, 32'd0);
      chk("reset a flush_cnt", 32'(a_fcnt), 32'd0);
      chk("reset a timeout", 32'(a_to), 32'd0);
      chk("reset b flush_cnt", 32'(b_fcnt), 32'd0);
      rst = 1'b1;

      for (int i = 0; i < 19; i++) begin
         apply_a(vecs[i]);
         check_a(i);
      end

      // Abort a flush with an asynchronous reset
      apply_a(mk(4'b0000, 1, 1, 32'hDEAD_BEEF, 6'b0, 0, 32'h20, 32'd8, 16'd3));
      check_a(100);
      apply_a(mk(4'b0000, 0, 0, 32'h0, 6'b0, 1, 32'hDEAD_BEEF, 32'd8, 16'd4));
      check_a(101);
      #2;
      rst = 1'b0;
      #1;
      chk("async rst flush", 32'(a_flush), 32'd0);
      chk("async rst new_pc", a_pc, 32'd0);
      chk("async rst stall_cnt", a_scnt, 32'd0);
      chk("async rst flush_cnt", 32'(a_fcnt), 32'd0);
      chk("async rst timeout", 32'(a_to), 32'd0);
      @(posedge clk);
      #1;
      rst = 1'b1;
      apply_a(mk(4'b0000, 0, 0, 32'h0, 6'b0, 0, 32'h0, 32'd0, 16'd0));
      check_a(102);
      apply_a(mk(4'b0001, 0, 0, 32'h0, 6'b000011, 0, 32'h0, 32'd0, 16'd0));
      check_a(103);
      apply_a(mk(4'b0000, 0, 0, 32'h0, 6'b0, 0, 32'h0, 32'd1, 16'd0));
      check_a(104);

      // ERET with a three-cycle flush; an exception inside the flush is dropped
      step_b(4'b0000, 1, 1, 32'h8000_1234);
      chk("eret b stall cycle N", 32'(b_stall), 32'd0);
      chk("eret b flush cycle N", 32'(b_flush), 32'd0);
      for (int c = 1; c <= 3; c++) begin
         step_b(4'b1000, (c == 2), 1'b0, 32'h0);
         chk($sformatf("eret b flush c%0d", c), 32'(b_flush), 32'd1);
         chk($sformatf("eret b stall c%0d", c), 32'(b_stall), 32'd0);
         chk($sformatf("eret b new_pc c%0d", c), b_pc, 32'h8000_1234);
      end
      step_b(4'b0000, 0, 0, 32'h0);
      chk("eret b flush after", 32'(b_flush), 32'd0);
      chk("eret b new_pc after", b_pc, 32'h8000_1234);
      chk("eret b flush_cnt", 32'(b_fcnt), 32'd1);
      chk("eret b stall_cnt", b_scnt, 32'd0);

      // Watchdog: 7 stalled, 1 idle, then 8 stalled cycles
      for (int c = 0; c < 7; c++) begin
         step_b(4'b0001, 0, 0, 32'h0);
         chk($sformatf("wd run1 c%0d timeout", c), 32'(b_to), 32'd0);
      end
      step_b(4'b0000, 0, 0, 32'h0);
      chk("wd gap timeout", 32'(b_to), 32'd0);
      for (int c = 0; c < 8; c++) begin
         step_b(4'b0001, 0, 0, 32'h0);
         chk($sformatf("wd run2 c%0d timeout", c), 32'(b_to), 32'd0);
         chk($sformatf("wd run2 c%0d stall", c), 32'(b_stall), 32'(6'b000011));
      end
      for (int c = 0; c < 3; c++) begin
         step_b(4'b0000, 0, 0, 32'h0);
         chk($sformatf("wd sticky c%0d", c), 32'(b_to), 32'd1);
      end
      step_b(4'b0010, 0, 0, 32'h0);
      chk("wd stall unaffected", 32'(b_stall), 32'(6'b000111));
      chk("wd b stall_cnt", b_scnt, 32'd15);
      step_b(4'b0000, 0, 0, 32'h0);

      // Saturation on a narrow counter
      for (int c = 1; c <= 20; c++) begin
         @(posedge clk);
         #1;
         sat_inc = 1'b1;
         @(negedge clk);
         chk($sformatf("sat c%0d", c), 32'(sat_cnt), 32'(c - 1 > 15 ? 15 : c - 1));
      end
      @(posedge clk);
      #1;
      sat_inc = 1'b0;
      chk("sat hold", 32'(sat_cnt), 32'd15);
      sat_clr = 1'b1;
      @(posedge clk);
      #1;
      sat_clr = 1'b0;
      chk("sat clear", 32'(sat_cnt), 32'd0);

      $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_err);
      $finish;
   end

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
Central stall/flush sequencer for the 5-stage MIPS32 pipeline.
- Collects stall requests from IF, ID, EX and MEM, and drives a per-stage stall vector to the PC register and to the if_id, id_ex, ex_mem and mem_wb pipeline registers.
- Sequences exception/ERET redirects: registered multi-cycle flush plus redirect PC.
- Keeps stall/flush performance counters and a stall-timeout watchdog.

Parameters:
FLUSH_CYCLES, 1, cycles flush is held after an accepted exception/ERET (1..7)
EXCP_VECTOR, 32'h0000_0020, redirect PC for a non-ERET exception
STALL_TIMEOUT, 1024, continuous-stall cycles before stall_timeout sets (2..65535)

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-low reset
stallreq_if  in  1  IF stage requests stall (instruction fetch wait)
stallreq_id  in  1  ID stage requests stall (load-use hazard)
stallreq_ex  in  1  EX stage requests stall (multi-cycle mul/div)
stallreq_mem  in  1  MEM stage requests stall (data bus wait)
excp_req  in  1  single-cycle pulse from MEM: exception or ERET committed
excp_eret  in  1  qualifies excp_req: 1 = ERET, 0 = exception
epc  in  32  return PC, sampled with excp_req when excp_eret=1
stall  out  6  [0]=PC, [1]=IF/ID, [2]=ID/EX, [3]=EX/MEM, [4]=MEM/WB, [5]=WB; 1 = hold
flush  out  1  clear all pipeline registers and load new_pc into PC
new_pc  out  32  redirect target, valid while flush=1
stall_cnt  out  32  saturating count of cycles with stall!=0
flush_cnt  out  16  saturating count of accepted redirects
stall_timeout  out  1  sticky: a stall persisted STALL_TIMEOUT cycles

Behaviour:
- Reset: rst low asynchronously forces the following, regardless of activity in progress (any flush is aborted):
  - state=RUN
  - stall=0, flush=0, new_pc=0
  - stall_cnt=0, flush_cnt=0, stall_timeout=0
  - internal flush and timeout counters = 0
- States:
  - RUN: no requests.
  - STALL: at least one stallreq_* high.
  - FLUSH: redirect in progress.
- Stall vector is combinational from the requests in RUN/STALL. Highest stage wins:
  - mem -> 6'b011111
  - ex -> 6'b001111
  - id -> 6'b000111
  - if -> 6'b000011
  - none -> 0
- State is registered and tracks the requests: RUN<->STALL follows (|stallreq_*) each cycle.
- Exception/ERET:
  - excp_req=1 in RUN or STALL in cycle N has priority over all stall requests. Stall is forced to 0 in cycle N.
  - At edge N, the block registers new_pc = excp_eret ? epc : EXCP_VECTOR, enters FLUSH, and increments flush_cnt.
  - flush=1 in cycles N+1 .. N+FLUSH_CYCLES, with stall=0 throughout.
  - After the last flush cycle, state = STALL if any request is high, else RUN.
- During FLUSH: excp_req and all stallreq_* are ignored; they are neither queued nor counted.
- new_pc holds its last value after flush drops.
- stall_cnt: +1 each cycle stall!=0; saturates at 32'hFFFF_FFFF.
- flush_cnt: saturates at 16'hFFFF.
- Watchdog:
  - An internal 16-bit counter increments each cycle stall!=0 and clears on any cycle with stall==0.
  - When it reaches STALL_TIMEOUT, stall_timeout sets and stays set until reset.
  - It has no effect on the stall outputs.
- Simultaneous events:
  - excp_req together with stallreq_mem: exception wins.
  - excp_req in the final flush cycle: ignored.

Decomposition:
- Shared define file (the existing project-wide header): stage-index constants, the four stall-vector encodings, and state encodings RUN/STALL/FLUSH.
- One natural sub-module: sat_counter (parameterised width, inc input, synchronous clear, saturating). Instantiated for stall_cnt and flush_cnt.
- Watchdog and flush counters stay inline.

Test Plan:
1. Reset mid-flush: pulse excp_req, then drop rst one cycle later -> flush=0, new_pc=0 and all counters 0 immediately (asynchronously); state=RUN after release.
2. Stall priority: stallreq_id=1 and stallreq_ex=1 for 3 cycles -> stall=6'b001111 in each of those cycles, stall_cnt=3, then stall=0 when both drop.
3. Exception with default FLUSH_CYCLES=1: excp_req=1, excp_eret=0 while stallreq_mem=1 -> stall=0 in the same cycle; next cycle flush=1 and new_pc=32'h0000_0020; flush_cnt=1; then stall=6'b011111 if stallreq_mem is still high.
4. ERET with FLUSH_CYCLES=3: excp_req=1, excp_eret=1, epc=32'h8000_1234 -> flush high for exactly 3 cycles, new_pc=32'h8000_1234. A second excp_req in flush cycle 2 is ignored: flush_cnt=1 and new_pc is unchanged.
5. Watchdog with STALL_TIMEOUT=8: stallreq_if held 7 cycles, released 1 cycle, then held 8 cycles -> stall_timeout stays 0 until the 8th continuous cycle, then stays 1 after the request drops.
6. Saturation: force stall_cnt near 32'hFFFF_FFFE (or use a reduced-width sat_counter) and hold a stall request -> count stops at all-ones with no wrap.
